// File: rtl/mainm_cache_pkg.sv
// Shared definitions for the mainm word cache: controller states and line geometry.
package mainm_cache_pkg;

   localparam int CACHE_IDX_W = 8;
   localparam int CACHE_TAG_W = 30 - CACHE_IDX_W;

   typedef enum logic [2:0] {
      ST_SWEEP,
      ST_IDLE,
      ST_LOOKUP,
      ST_FILL,
      ST_WRITE,
      ST_RESP
   } state_e;

   // A line is {valid, tag, data}; the tag covers address bits above the index.
   function automatic int line_w(input int idx_w);
      return 1 + (30 - idx_w) + 32;
   endfunction

endpackage

// File: rtl/mainm_cache_line_ram.sv
// Single-port line store with registered read (read-before-write on the same address).
module cache_line_ram
   import mainm_cache_pkg::*;
#(
   parameter int W  = line_w(CACHE_IDX_W),
   parameter int AW = CACHE_IDX_W
) (
   input  logic          clk,
   input  logic [AW-1:0] a,
   input  logic [W-1:0]  d,
   input  logic          we,
   output logic [W-1:0]  spo
);

   logic [W-1:0] mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (we)
         mem_q[a] <= d;
      spo <= mem_q[a];
   end

endmodule

// File: rtl/mainm_cache.sv
// Direct-mapped write-through/write-allocate word cache between the mapper and the PSRAM controller.
module mainm_cache
   import mainm_cache_pkg::*;
#(
   parameter int IDX_W = CACHE_IDX_W
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] d,
   input  logic        we,
   input  logic        rd,
   output logic [31:0] spo,
   output logic        ready,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] m_a,
   output logic [31:0] m_d,
   output logic        m_we,
   output logic        m_rd,
   input  logic [31:0] m_spo,
   input  logic        m_ready
);

   localparam int TAG_W  = 30 - IDX_W;
   localparam int LINE_W = line_w(IDX_W);
   localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

   state_e             state_q, state_d;
   logic [IDX_W:0]     cnt_q, cnt_d;
   logic               flush_pend_q, flush_pend_d;
   logic [31:2]        addr_q, addr_d;
   logic [31:0]        spo_q, spo_d;
   logic [31:0]        m_a_q, m_a_d;
   logic [31:0]        m_d_q, m_d_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               m_we_q, m_we_d;
   logic               m_rd_q, m_rd_d;

   logic [IDX_W-1:0]   ram_a;
   logic [LINE_W-1:0]  ram_d, ram_spo;
   logic               ram_we;
   logic               ram_valid;
   logic [TAG_W-1:0]   ram_tag;
   logic [31:0]        ram_data;
   logic               hit;
   logic               flush_req;
   logic               unused_addr_lsbs;

   cache_line_ram #(.W(LINE_W), .AW(IDX_W)) u_ram (
      .clk (clk),
      .a   (ram_a),
      .d   (ram_d),
      .we  (ram_we),
      .spo (ram_spo)
   );

   assign {ram_valid, ram_tag, ram_data} = ram_spo;
   assign hit              = ram_valid && (ram_tag == addr_q[31:IDX_W+2]);
   assign flush_req        = flush_pend_q || flush;
   assign unused_addr_lsbs = ^a[1:0];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      flush_pend_d = flush_pend_q || flush;
      addr_d       = addr_q;
      spo_d        = spo_q;
      m_a_d        = m_a_q;
      m_d_d        = m_d_q;
      ready_d      = 1'b0;
      m_we_d       = m_we_q;
      m_rd_d       = m_rd_q;
      ram_a        = addr_q[IDX_W+1:2];
      ram_d        = {1'b1, addr_q[31:IDX_W+2], m_spo};
      ram_we       = 1'b0;

      case (state_q)
         ST_SWEEP: begin
            // A flush arriving mid-sweep simply restarts the sweep from line 0.
            ram_a        = cnt_q[IDX_W-1:0];
            ram_d        = '0;
            ram_we       = 1'b1;
            flush_pend_d = 1'b0;
            if (flush) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_d[IDX_W])
                  state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            ram_a = a[IDX_W+1:2];
            if (we) begin
               addr_d  = a[31:2];
               ram_d   = {1'b1, a[31:IDX_W+2], d};
               ram_we  = 1'b1;
               m_a_d   = {a[31:2], 2'b00};
               m_d_d   = d;
               m_we_d  = 1'b1;
               state_d = ST_WRITE;
            end else if (rd) begin
               addr_d  = a[31:2];
               state_d = ST_LOOKUP;
            end else if (flush_req) begin
               state_d      = ST_SWEEP;
               cnt_d        = '0;
               flush_pend_d = 1'b0;
            end
         end
         ST_LOOKUP: begin
            if (hit) begin
               spo_d   = ram_data;
               ready_d = 1'b1;
               state_d = ST_RESP;
            end else begin
               m_a_d   = {addr_q, 2'b00};
               m_rd_d  = 1'b1;
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            if (m_ready) begin
               m_rd_d  = 1'b0;
               ram_we  = 1'b1;
               spo_d   = m_spo;
               ready_d = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_WRITE: begin
            if (m_ready) begin
               m_we_d  = 1'b0;
               ready_d = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            if (flush_req) begin
               state_d      = ST_SWEEP;
               cnt_d        = '0;
               flush_pend_d = 1'b0;
            end
         end
         default: state_d = ST_SWEEP;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_SWEEP;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
         addr_q       <= '0;
         spo_q        <= '0;
         m_a_q        <= '0;
         m_d_q        <= '0;
         ready_q      <= 1'b0;
         busy_q       <= 1'b1;
         m_we_q       <= 1'b0;
         m_rd_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
         addr_q       <= addr_d;
         spo_q        <= spo_d;
         m_a_q        <= m_a_d;
         m_d_q        <= m_d_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
         m_we_q       <= m_we_d;
         m_rd_q       <= m_rd_d;
      end
   end

   assign spo   = spo_q;
   assign ready = ready_q;
   assign busy  = busy_q;
   assign m_a   = m_a_q;
   assign m_d   = m_d_q;
   assign m_we  = m_we_q;
   assign m_rd  = m_rd_q;

endmodule

// File: tb/tb_mainm_cache.sv
// Bench for mainm_cache: PSRAM controller model, scripted vectors, corner sequences and random traffic.
module tb_mainm_cache;

   logic        clk, rst, we, rd, flush, ready, busy, m_we, m_rd, m_ready;
   logic [31:0] a, d, spo, m_a, m_d, m_spo;

   int total = 0;
   int bad = 0;
   int mrd_cnt = 0;
   int mwe_cnt = 0;
   int mem_lat = 3;
   logic [31:0] last_ma = '0;
   logic [31:0] last_md = '0;

   logic [31:0] mem_store [logic [31:0]];
   logic [31:0] ref_mem   [logic [31:0]];
   logic [31:0] mdl_line  [int];

   typedef struct {
      bit          w;
      bit          r;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_spo;
      int          exp_mrd;
      int          exp_mwe;
      int          exp_lat;
   } vec_t;

   vec_t vecs[6];

   mainm_cache #(.IDX_W(8)) dut (
      .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready),
      .flush(flush), .busy(busy), .m_a(m_a), .m_d(m_d), .m_we(m_we), .m_rd(m_rd),
      .m_spo(m_spo), .m_ready(m_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] defval(input logic [31:0] wa);
      return wa ^ 32'h5A5A_3C3C;
   endfunction

   function automatic logic [31:0] mem_get(input logic [31:0] wa);
      return mem_store.exists(wa) ? mem_store[wa] : defval(wa);
   endfunction

   function automatic logic [31:0] ref_get(input logic [31:0] wa);
      return ref_mem.exists(wa) ? ref_mem[wa] : defval(wa);
   endfunction

   function automatic int idx_of(input logic [31:0] wa);
      return int'((wa >> 2) & 32'hFF);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference cache: each slot remembers which word address it currently holds.
   task automatic model_note(input bit w, input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] wa;
      wa = addr & ~32'h3;
      if (w)
         ref_mem[wa] = data;
      mdl_line[idx_of(wa)] = wa;
   endtask

   // PSRAM controller: fixed latency from strobe to a one-cycle m_ready.
   initial begin
      int  wait_cnt;
      bit  resp_sent;
      m_ready   = 1'b0;
      m_spo     = '0;
      wait_cnt  = -1;
      resp_sent = 1'b0;
      forever begin
         @(negedge clk);
         m_ready = 1'b0;
         if (m_rd || m_we) begin
            if (!resp_sent) begin
               if (wait_cnt < 0) begin
                  wait_cnt = mem_lat;
                  last_ma  = m_a;
                  last_md  = m_d;
                  if (m_we) mwe_cnt++;
                  else      mrd_cnt++;
               end
               if (wait_cnt == 0) begin
                  m_ready   = 1'b1;
                  resp_sent = 1'b1;
                  wait_cnt  = -1;
                  if (m_we) mem_store[m_a] = m_d;
                  else      m_spo = mem_get(m_a);
               end else begin
                  wait_cnt--;
               end
            end
         end else begin
            resp_sent = 1'b0;
            wait_cnt  = -1;
         end
      end
   end

   initial begin
      bit prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (prev)
            chk("ready_one_cycle", {31'b0, ready}, 32'd0);
         prev = ready;
      end
   end

   task automatic count_busy(output int n);
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         if (!busy) break;
         n++;
         @(negedge clk);
      end
   endtask

   task automatic wait_ready(output bit got);
      got = 1'b0;
      for (int i = 0; i < 600 && !got; i++) begin
         @(negedge clk);
         if (ready) got = 1'b1;
      end
   endtask

   task automatic do_req(input bit w, input bit r, input logic [31:0] addr, input logic [31:0] data,
                         input bit flush_in_fill, output logic [31:0] rdata, output int lat,
                         output int dmrd, output int dmwe);
      int r0, w0;
      bit got, fl;
      @(negedge clk);
      r0 = mrd_cnt;
      w0 = mwe_cnt;
      a = addr; d = data; we = w; rd = r;
      got = 1'b0; fl = 1'b0; lat = 0;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (flush) flush = 1'b0;
         if (flush_in_fill && !fl && m_rd) begin
            flush = 1'b1;
            fl    = 1'b1;
         end
         if (ready) got = 1'b1;
      end
      rdata = spo;
      we = 1'b0; rd = 1'b0;
      dmrd = mrd_cnt - r0;
      dmwe = mwe_cnt - w0;
      chk("req_completed", {31'b0, got}, 32'd1);
      $display("req we=%0d rd=%0d a=%h d=%h spo=%h lat=%0d m_rd=%0d m_we=%0d",
               w, r, addr, data, rdata, lat, dmrd, dmwe);
   endtask

   initial begin
      logic [31:0] rdata, addr, wa, data;
      int          lat, dmrd, dmwe, n, r0, w0, idx, tg;
      bit          got, w, r, exp_hit, fl_now;

      rst = 1'b1; a = '0; d = '0; we = 1'b0; rd = 1'b0; flush = 1'b0;
      mem_store[32'h2000_0010] = 32'hDEAD_BEEF;
      mem_store[32'h2000_0410] = 32'h1234_5678;
      ref_mem[32'h2000_0010]   = 32'hDEAD_BEEF;
      ref_mem[32'h2000_0410]   = 32'h1234_5678;

      vecs[0] = '{1'b0, 1'b1, 32'h2000_0010, 32'h0,         32'hDEAD_BEEF, 0, 0, 2};
      vecs[1] = '{1'b0, 1'b1, 32'h2000_0410, 32'h0,         32'h1234_5678, 1, 0, 0};
      vecs[2] = '{1'b0, 1'b1, 32'h2000_0010, 32'h0,         32'hDEAD_BEEF, 1, 0, 0};
      vecs[3] = '{1'b1, 1'b0, 32'h2000_0020, 32'hCAFE_F00D, 32'h0,         0, 1, 0};
      vecs[4] = '{1'b0, 1'b1, 32'h2000_0020, 32'h0,         32'hCAFE_F00D, 0, 0, 2};
      vecs[5] = '{1'b0, 1'b1, 32'h2000_0413, 32'h0,         32'h1234_5678, 1, 0, 0};

      // Reset values, then a read held through the initial sweep.
      repeat (3) @(negedge clk);
      mem_lat = 20;
      rst = 1'b0;
      chk("rst_spo",   spo,           32'h0);
      chk("rst_ready", {31'b0, ready}, 32'd0);
      chk("rst_busy",  {31'b0, busy},  32'd1);
      chk("rst_m_a",   m_a,           32'h0);
      chk("rst_m_d",   m_d,           32'h0);
      chk("rst_m_we",  {31'b0, m_we},  32'd0);
      chk("rst_m_rd",  {31'b0, m_rd},  32'd0);
      r0 = mrd_cnt;
      a = 32'h2000_0010; rd = 1'b1;
      count_busy(n);
      chk("reset_sweep_cycles", n, 32'd256);
      wait_ready(got);
      chk("first_read_ready", {31'b0, got}, 32'd1);
      chk("first_read_spo", spo, 32'hDEAD_BEEF);
      chk("first_read_m_rd", mrd_cnt - r0, 32'd1);
      chk("first_read_m_a", last_ma, 32'h2000_0010);
      rd = 1'b0;
      $display("req we=0 rd=1 a=20000010 spo=%h (held through sweep)", spo);
      model_note(1'b0, 32'h2000_0010, 32'h0);

      mem_lat = 3;
      for (int i = 0; i < 6; i++) begin
         do_req(vecs[i].w, vecs[i].r, vecs[i].addr, vecs[i].data, 1'b0, rdata, lat, dmrd, dmwe);
         if (!vecs[i].w)
            chk("tbl_spo", rdata, vecs[i].exp_spo);
         chk("tbl_m_rd_count", dmrd, vecs[i].exp_mrd);
         chk("tbl_m_we_count", dmwe, vecs[i].exp_mwe);
         if (vecs[i].exp_lat != 0)
            chk("tbl_hit_latency", lat, vecs[i].exp_lat);
         if (vecs[i].exp_mrd + vecs[i].exp_mwe != 0)
            chk("tbl_m_a", last_ma, vecs[i].addr & ~32'h3);
         if (vecs[i].w)
            chk("tbl_m_d", last_md, vecs[i].data);
         model_note(vecs[i].w, vecs[i].addr, vecs[i].data);
      end

      // Flush pulse while a fill is outstanding.
      mem_lat = 20;
      do_req(1'b0, 1'b1, 32'h2000_0030, 32'h0, 1'b1, rdata, lat, dmrd, dmwe);
      chk("flushfill_spo", rdata, defval(32'h2000_0030));
      chk("flushfill_m_rd", dmrd, 32'd1);
      @(negedge clk);
      count_busy(n);
      chk("flush_sweep_cycles", n, 32'd256);
      mdl_line.delete();
      mem_lat = 3;
      do_req(1'b0, 1'b1, 32'h2000_0020, 32'h0, 1'b0, rdata, lat, dmrd, dmwe);
      chk("postflush_spo", rdata, 32'hCAFE_F00D);
      chk("postflush_m_rd", dmrd, 32'd1);
      model_note(1'b0, 32'h2000_0020, 32'h0);

      // Random traffic over a few colliding lines.
      for (int k = 0; k < 120; k++) begin
         fl_now = ($urandom_range(0, 15) == 0);
         if (fl_now) begin
            @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            mdl_line.delete();
         end
         w    = ($urandom_range(0, 2) == 0);
         r    = !w || ($urandom_range(0, 1) == 1);
         idx  = $urandom_range(0, 3);
         tg   = $urandom_range(0, 2);
         addr = 32'h3000_0000 | (32'(tg) << 10) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
         wa   = addr & ~32'h3;
         data = $urandom;
         exp_hit = mdl_line.exists(idx_of(wa)) && (mdl_line[idx_of(wa)] == wa);
         mem_lat = $urandom_range(0, 6);
         do_req(w, r, addr, data, 1'b0, rdata, lat, dmrd, dmwe);
         if (w) begin
            chk("rnd_wr_m_we", dmwe, 32'd1);
            chk("rnd_wr_m_rd", dmrd, 32'd0);
            chk("rnd_wr_m_a", last_ma, wa);
            chk("rnd_wr_m_d", last_md, data);
         end else begin
            chk("rnd_rd_spo", rdata, ref_get(wa));
            chk("rnd_rd_m_rd", dmrd, exp_hit ? 32'd0 : 32'd1);
            chk("rnd_rd_m_we", dmwe, 32'd0);
            if (exp_hit && !fl_now)
               chk("rnd_hit_latency", lat, 32'd2);
         end
         model_note(w, addr, data);
      end

      // Reset in the middle of a fill, with rd and we both held afterwards.
      @(negedge clk);
      mem_lat = 50;
      a = 32'h2000_0040; rd = 1'b1; we = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (m_rd) got = 1'b1;
      end
      chk("fill_reached", {31'b0, got}, 32'd1);
      rst = 1'b1;
      a = 32'h2000_0050; d = 32'h0BAD_C0DE; we = 1'b1;
      r0 = mrd_cnt; w0 = mwe_cnt;
      @(negedge clk);
      chk("rstfill_m_rd",  {31'b0, m_rd},  32'd0);
      chk("rstfill_ready", {31'b0, ready}, 32'd0);
      chk("rstfill_busy",  {31'b0, busy},  32'd1);
      chk("rstfill_m_we",  {31'b0, m_we},  32'd0);
      mem_lat = 4;
      rst = 1'b0;
      count_busy(n);
      chk("rstfill_sweep_cycles", n, 32'd256);
      wait_ready(got);
      chk("rdwe_ready", {31'b0, got}, 32'd1);
      chk("rdwe_m_we_count", mwe_cnt - w0, 32'd1);
      chk("rdwe_m_rd_count", mrd_cnt - r0, 32'd0);
      chk("rdwe_m_a", last_ma, 32'h2000_0050);
      chk("rdwe_m_d", last_md, 32'h0BAD_C0DE);
      we = 1'b0; rd = 1'b0;
      $display("req we=1 rd=1 a=20000050 d=0badc0de (held through sweep)");
      mdl_line.delete();
      model_note(1'b1, 32'h2000_0050, 32'h0BAD_C0DE);
      do_req(1'b0, 1'b1, 32'h2000_0050, 32'h0, 1'b0, rdata, lat, dmrd, dmwe);
      chk("rdwe_readback_spo", rdata, 32'h0BAD_C0DE);
      chk("rdwe_readback_m_rd", dmrd, 32'd0);
      chk("rdwe_readback_latency", lat, 32'd2);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
